// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the SRAM request controller.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH / DEF_RESP_DEPTH : parameter defaults
//   rd_state_e      : read pipeline state (idle / read data due from macro)
//   expand_byte_en  : turns one byte-enable bit into an 8-bit write mask
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 9;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_RESP_DEPTH = 2;

  typedef enum logic {
    RD_IDLE     = 1'b0,
    RD_INFLIGHT = 1'b1
  } rd_state_e;

  function automatic logic [7:0] expand_byte_en(input logic en);
    return {8{en}};
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// -----------------------------------------------------------------------------
// sram_resp_fifo
// Synchronous DEPTH-entry FIFO holding read data returned by the SRAM macro.
//   clk, reset   : clock, synchronous active-high reset (clears pointers/count)
//   push         : write push_data (ignored when full unless popping)
//   push_data    : data to store
//   pop          : remove head entry (ignored when empty)
//   pop_data     : head entry, stable until popped
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sram_resp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// -----------------------------------------------------------------------------
// sram_req_ctrl
// Valid/ready front end for a single-port SRAM macro with 1-cycle read
// latency. Requests fire straight onto the macro pins; read data is captured
// one cycle later into a response FIFO and returned in order (latency 2).
// Credits (in-flight + buffered reads) throttle req_ready so the FIFO never
// overflows.
//   clk, reset                  : clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake
//   req_write, req_addr,
//   req_wdata, req_bmask        : request payload (byte enables for writes)
//   resp_valid/resp_ready       : read response handshake
//   resp_rdata                  : read data, in request order
//   sram_csb, sram_web          : active-low chip select / write enable
//   sram_wmask, sram_addr,
//   sram_din                    : macro bit mask, address, write data
//   sram_dout                   : macro read data (valid only after a read)
//   busy                        : any read in flight or buffered
// -----------------------------------------------------------------------------
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RESP_DEPTH = DEF_RESP_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_bmask,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic [DATA_WIDTH-1:0]   sram_wmask,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_din,
  input  logic [DATA_WIDTH-1:0]   sram_dout,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  rd_state_e        rd_state;
  logic             fire;
  logic             rd_fire;
  logic             wr_fire;
  logic             pop;
  logic             in_flight;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credits;
  logic [CNT_W:0]   credits_after_pop;
  logic [DATA_WIDTH-1:0] wmask_expanded;

  // ---------------------------------------------------------------------------
  // Handshakes and credits
  // ---------------------------------------------------------------------------
  assign in_flight = (rd_state == RD_INFLIGHT);
  assign resp_valid = ~reset & ~fifo_empty;
  assign pop        = resp_valid & resp_ready;

  always_comb begin
    credits           = {1'b0, fifo_count} + (CNT_W + 1)'(in_flight);
    // A pop in this cycle frees its credit immediately, so a stalled
    // requester can fire in the very cycle the consumer drains an entry.
    credits_after_pop = credits - (CNT_W + 1)'(pop);
  end

  assign req_ready = ~reset & (credits_after_pop < (CNT_W + 1)'(RESP_DEPTH));
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req_write;
  assign wr_fire   = fire & req_write;
  assign busy      = ~reset & (in_flight | ~fifo_empty);

  // ---------------------------------------------------------------------------
  // Macro pins, driven combinationally in the fire cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    wmask_expanded = '0;
    for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
      wmask_expanded[8*i +: 8] = expand_byte_en(req_bmask[i]);
    end
  end

  assign sram_csb   = ~fire;
  assign sram_web   = ~wr_fire;
  assign sram_wmask = wr_fire ? wmask_expanded : '0;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;

  // ---------------------------------------------------------------------------
  // Read pipeline: RD_INFLIGHT marks the cycle in which sram_dout is valid
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_IDLE;
    end else begin
      case (rd_state)
        RD_IDLE:     rd_state <= rd_fire ? RD_INFLIGHT : RD_IDLE;
        RD_INFLIGHT: rd_state <= rd_fire ? RD_INFLIGHT : RD_IDLE;
        default:     rd_state <= RD_IDLE;
      endcase
    end
  end

  // Reset inside the FIFO outranks the push, so a read in flight when reset
  // arrives is dropped rather than captured.
  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight),
    .push_data (sram_dout),
    .pop       (pop),
    .pop_data  (resp_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Credit gating must make a capture into a full, non-draining FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(fifo_full && in_flight && !pop));

endmodule

// File: tb/tb_sram_req_ctrl.sv
module tb_sram_req_ctrl;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_bmask;
  logic            resp_valid;
  logic            resp_ready;
  logic [DW-1:0]   resp_rdata;
  logic            sram_csb;
  logic            sram_web;
  logic [DW-1:0]   sram_wmask;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_din;
  logic [DW-1:0]   sram_dout;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
  } op_t;

  sram_req_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_bmask  (req_bmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {16'hC0DE, 7'd0, a};
  endfunction

  // Macro model: 1-cycle read latency, X on dout except after a read.
  // Contents reload on reset so scenarios start from a known pattern.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(AW'(i));
    end
    if (!sram_csb && !sram_web) begin
      mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_din & sram_wmask);
      sram_dout <= 'x;
    end else if (!sram_csb) begin
      sram_dout <= mem[sram_addr];
    end else begin
      sram_dout <= 'x;
    end
  end

  // Scoreboard: every accepted response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got %h expected no response", resp_rdata);
      end else begin
        exp_word = exp_q.pop_front();
        if (resp_rdata !== exp_word) begin
          errors++;
          $display("FAIL resp_rdata: got %h expected %h", resp_rdata, exp_word);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_bmask = '0;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] m);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_bmask = m;
  endtask

  task automatic drain(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      smp();
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    resp_ready = 1'b1;
    drive(1'b0, 9'h003, '0, '0);
    cyc();
    cyc();
    smp();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (sram_csb !== 1'b1) begin errors++; $display("FAIL rst_csb: got %b expected 1", sram_csb); end
    cyc();
    reset = 1'b0;
    idle();
    smp();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write_read();
    logic ok;
    cyc();
    resp_ready = 1'b1;
    drive(1'b1, 9'h005, 32'hDEADBEEF, 4'hF);
    smp();
    checks++; if (sram_csb !== 1'b0) begin errors++; $display("FAIL wr_csb: got %b expected 0", sram_csb); end
    checks++; if (sram_web !== 1'b0) begin errors++; $display("FAIL wr_web: got %b expected 0", sram_web); end
    checks++; if (sram_wmask !== 32'hFFFFFFFF) begin errors++; $display("FAIL wr_wmask: got %h expected ffffffff", sram_wmask); end
    checks++; if (sram_addr !== 9'h005) begin errors++; $display("FAIL wr_addr: got %h expected 005", sram_addr); end
    checks++; if (sram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_din: got %h expected deadbeef", sram_din); end
    cyc();
    drive(1'b0, 9'h005, 32'h0, 4'hF);
    smp();
    checks++; if (sram_csb !== 1'b0) begin errors++; $display("FAIL rd_csb: got %b expected 0", sram_csb); end
    checks++; if (sram_web !== 1'b1) begin errors++; $display("FAIL rd_web: got %b expected 1", sram_web); end
    checks++; if (sram_wmask !== 32'h0) begin errors++; $display("FAIL rd_wmask: got %h expected 00000000", sram_wmask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_no_credit: got busy=%b expected 0", busy); end
    exp_q.push_back(32'hDEADBEEF);
    cyc();
    idle();
    smp();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lat_n1_valid: got %b expected 0", resp_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_n1_busy: got %b expected 1", busy); end
    cyc();
    smp();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lat_n2_valid: got %b expected 1", resp_valid); end
    cyc();
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_rd_drain: got pending=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_bmask();
    logic ok;
    cyc();
    drive(1'b1, 9'h010, 32'hFFFFFFFF, 4'hF);
    smp();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bm_ready: got %b expected 1", req_ready); end
    cyc();
    drive(1'b1, 9'h010, 32'h00000000, 4'h2);
    smp();
    checks++; if (sram_wmask !== 32'h0000FF00) begin errors++; $display("FAIL bm_wmask: got %h expected 0000ff00", sram_wmask); end
    cyc();
    drive(1'b0, 9'h010, '0, '0);
    smp();
    exp_q.push_back(32'hFFFF00FF);
    cyc();
    idle();
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bm_drain: got pending=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic ok;
    cyc();
    resp_ready = 1'b0;
    drive(1'b0, 9'h020, '0, '0);
    smp();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", req_ready); end
    exp_q.push_back(init_word(9'h020));
    cyc();
    drive(1'b0, 9'h021, '0, '0);
    smp();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2: got %b expected 1", req_ready); end
    exp_q.push_back(init_word(9'h021));
    cyc();
    drive(1'b0, 9'h022, '0, '0);
    for (int i = 0; i < 4; i++) begin
      smp();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0", req_ready); end
      checks++; if (sram_csb !== 1'b1) begin errors++; $display("FAIL bp_stall_csb: got %b expected 1", sram_csb); end
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== init_word(9'h020)) begin
        errors++; $display("FAIL bp_hold: got valid=%b data=%h expected 1 %h", resp_valid, resp_rdata, init_word(9'h020));
      end
      cyc();
    end
    resp_ready = 1'b1;
    smp();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_ready: got %b expected 1", req_ready); end
    checks++; if (sram_csb !== 1'b0) begin errors++; $display("FAIL bp_pop_csb: got %b expected 0", sram_csb); end
    exp_q.push_back(init_word(9'h022));
    cyc();
    idle();
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got pending=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    op_t ops[5];
    logic ok;
    logic ev;
    ops[0] = '{1'b0, 9'h000, 32'h0, init_word(9'h000)};
    ops[1] = '{1'b0, 9'h1FF, 32'h0, init_word(9'h1FF)};
    ops[2] = '{1'b1, 9'h1FF, 32'h12345678, 32'h0};
    ops[3] = '{1'b0, 9'h1FF, 32'h0, 32'h12345678};
    ops[4] = '{1'b0, 9'h000, 32'h0, init_word(9'h000)};
    resp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      cyc();
      if (c < 5) drive(ops[c].w, ops[c].a, ops[c].d, 4'hF);
      else idle();
      smp();
      if (c < 5) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", c, req_ready); end
        if (!ops[c].w) exp_q.push_back(ops[c].e);
      end
      ev = 1'b0;
      if (c >= 2) ev = ~ops[c-2].w;
      checks++; if (resp_valid !== ev) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", c, resp_valid, ev); end
    end
    cyc();
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got pending=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    cyc();
    resp_ready = 1'b1;
    drive(1'b0, 9'h005, '0, '0);
    smp();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_fire: got %b expected 1", req_ready); end
    cyc();
    reset = 1'b1;
    idle();
    smp();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", resp_valid); end
    checks++; if (sram_csb !== 1'b1) begin errors++; $display("FAIL mid_rst_csb: got %b expected 1", sram_csb); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", req_ready); end
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid[%0d]: got %b expected 0", i, resp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_post_busy[%0d]: got %b expected 0", i, busy); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready[%0d]: got %b expected 1", i, req_ready); end
      checks++; if (sram_csb !== 1'b1) begin errors++; $display("FAIL mid_post_csb[%0d]: got %b expected 1", i, sram_csb); end
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1;
    resp_ready = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_bmask();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_req_ctrl.md
SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter RESP_DEPTH, default 2, response buffer entries.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request offered.
REQ-007 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  word address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port req_bmask  input  DATA_WIDTH/8  byte write enables.
REQ-012 SHALL have port resp_valid  output  1  read data available.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts read data.
REQ-014 SHALL have port resp_rdata  output  DATA_WIDTH  read data, in request order.
REQ-015 SHALL have port sram_csb  output  1  active-low chip select to macro.
REQ-016 SHALL have port sram_web  output  1  active-low write enable to macro.
REQ-017 SHALL have port sram_wmask  output  DATA_WIDTH  per-bit write mask to macro.
REQ-018 SHALL have port sram_addr  output  ADDR_WIDTH  macro address.
REQ-019 SHALL have port sram_din  output  DATA_WIDTH  macro write data.
REQ-020 SHALL have port sram_dout  input  DATA_WIDTH  macro read data.
REQ-021 SHALL have port busy  output  1  high while any read is in flight or buffered.

Function
REQ-022 SHALL define fire = req_valid & req_ready; the macro samples its pins on the rising edge that ends the fire cycle.
REQ-023 SHALL drive sram_csb = ~fire, sram_web = ~req_write, sram_addr = req_addr, sram_din = req_wdata combinationally in the fire cycle.
REQ-024 SHALL expand byte mask: sram_wmask[8i+7:8i] = {8{req_bmask[i]}}; on reads, sram_wmask = all zeros.
REQ-025 SHALL keep sram_csb high in every cycle without fire, including during reset.
REQ-026 SHALL hold a 1-bit in-flight flag set for the cycle after a read fire (cycle N+1).
REQ-027 SHALL capture sram_dout into the response buffer at the rising edge ending cycle N+1; resp_valid first visible in cycle N+2 (read latency 2).
REQ-028 SHALL sample sram_dout only in in-flight cycles; the macro drives X at other times.
REQ-029 SHALL keep credit count = in-flight + buffered reads, 0..RESP_DEPTH.
REQ-030 SHALL drive req_ready = (credits < RESP_DEPTH), independent of req_valid and req_write.
REQ-031 SHALL allow back-to-back fires (one per cycle), mixing reads and writes.
REQ-032 SHALL pop the buffer when resp_valid & resp_ready; simultaneous capture and pop leave occupancy unchanged.
REQ-033 SHALL free a credit in the pop cycle, allowing req_ready to rise combinationally in that same cycle.
REQ-034 SHALL take no action on writes after the fire cycle: no response and no credit.
REQ-035 SHALL keep resp_rdata stable while resp_valid is high and resp_ready is low.
REQ-036 SHALL return read-after-write to the same address, on consecutive fires, the newly written data.

Reset
REQ-037 SHALL, while reset is high, force req_ready=0, resp_valid=0, busy=0, sram_csb=1, and clear the in-flight flag, credits and buffer pointers.
REQ-038 SHALL discard an in-flight read or buffered data when reset is asserted mid-operation; no response is produced after reset.

Structure
REQ-039 SHALL place ADDR_WIDTH, DATA_WIDTH, RESP_DEPTH defaults and the byte-mask expansion function in package sram_ctrl_pkg.
REQ-040 SHALL implement the response buffer as sub-module sram_resp_fifo (RESP_DEPTH-entry, synchronous, full/empty flags).

Verification
REQ-041 SHALL cover: write addr 0x005 data 0xDEADBEEF bmask 0xF, then read 0x005 -> resp_rdata 0xDEADBEEF two cycles after the read fire.
REQ-042 SHALL cover: write 0x010 = 0xFFFFFFFF, write 0x010 = 0x00000000 with bmask 0x2, read -> 0xFFFF00FF.
REQ-043 SHALL cover: resp_ready=0, three back-to-back reads -> two fire, req_ready low until one pop, third returns in order.
REQ-044 SHALL cover: reads to 0x000 and 0x1FF (wrap extremes) back-to-back with resp_ready=1 -> one response per cycle, correct order.
REQ-045 SHALL cover: reset asserted in cycle N+1 of a read -> resp_valid stays 0, credits return to 0, sram_csb=1.
